// File: rtl/cpu_dbg_pkg.sv
// Shared encodings for the debug-panel execution controller.
package cpu_dbg_pkg;

    localparam int unsigned PC_W_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_HALT = 2'b11
    } exec_state_t;

endpackage

// File: rtl/cpu_exec_ctrl_sync_edge.sv
// Two-flop synchroniser for a raw panel input, plus a rising-edge detector
// on the synchronised level.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;

endmodule

// File: rtl/cpu_exec_ctrl.sv
// Execution sequencer between the debug panel and the CPU: free run, N-cycle
// step, or halt on breakpoint / CPU halt request, with a saturating cycle count.
module cpu_exec_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned CYC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic [CNT_W-1:0] step_num,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    input  logic             halt_req,
    output logic             cpu_ce,
    output logic [1:0]       state,
    output logic             bp_hit,
    output logic [CYC_W-1:0] cycle_cnt
);

    logic             run_lv, run_re, step_p, step_lvl_unused;
    exec_state_t      state_q, state_d;
    logic [CNT_W-1:0] remaining;
    logic             skip, ce_q;
    logic             bp_match, stop, entry, load_step, set_bp;

    sync_edge u_run_sync (
        .clk   (clk),
        .rst   (rst),
        .d     (run),
        .level (run_lv),
        .rise  (run_re)
    );

    sync_edge u_step_sync (
        .clk   (clk),
        .rst   (rst),
        .d     (step),
        .level (step_lvl_unused),
        .rise  (step_p)
    );

    assign bp_match = bp_en & (pc == bp_addr) & ~skip;
    assign stop     = bp_match | halt_req;
    // The registered enable is masked by the live stop condition so the
    // instruction at a matching PC is never fetched.
    assign cpu_ce   = ce_q & ~stop;
    assign state    = state_q;

    always_comb begin
        state_d   = state_q;
        load_step = 1'b0;
        set_bp    = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (run_re) begin
                    state_d = S_RUN;
                end else if (step_p) begin
                    state_d   = S_STEP;
                    load_step = 1'b1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_HALT;
                    set_bp  = bp_match;
                end else if (!run_lv) begin
                    state_d = S_IDLE;
                end
            end
            S_STEP: begin
                if (stop) begin
                    state_d = S_HALT;
                    set_bp  = bp_match;
                end else if (remaining <= CNT_W'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign entry = ((state_q == S_IDLE) || (state_q == S_HALT)) &&
                   ((state_d == S_RUN)  || (state_d == S_STEP));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ce_q      <= 1'b0;
            skip      <= 1'b0;
            bp_hit    <= 1'b0;
            remaining <= '0;
            cycle_cnt <= '0;
        end else begin
            state_q <= state_d;
            ce_q    <= (state_d == S_RUN) || (state_d == S_STEP);
            skip    <= entry;

            if (set_bp)
                bp_hit <= 1'b1;
            else if (entry && (state_d == S_RUN))
                bp_hit <= 1'b0;

            if (load_step)
                remaining <= (step_num == '0) ? CNT_W'(1) : step_num;
            else if (state_q == S_STEP)
                remaining <= stop ? '0 : remaining - CNT_W'(1);

            if (cpu_ce && (cycle_cnt != '1))
                cycle_cnt <= cycle_cnt + CYC_W'(1);
        end
    end

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Directed bench for cpu_exec_ctrl: step-count table plus breakpoint, halt,
// reset and counter-saturation sequences.
module tb_cpu_exec_ctrl;

    logic        clk;
    logic        rst;
    logic        run, step, bp_en, halt_req;
    logic [7:0]  step_num;
    logic [31:0] bp_addr;
    logic [31:0] cpu_pc;
    logic        pc_clr;
    logic        cpu_ce;
    logic [1:0]  state;
    logic        bp_hit;
    logic [31:0] cycle_cnt;

    logic        run_s;
    logic        cpu_ce_s;
    logic [1:0]  state_s;
    logic        bp_hit_s;
    logic [3:0]  cycle_cnt_s;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    cpu_exec_ctrl #(.PC_W(32), .CNT_W(8), .CYC_W(32)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .step      (step),
        .step_num  (step_num),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .pc        (cpu_pc),
        .halt_req  (halt_req),
        .cpu_ce    (cpu_ce),
        .state     (state),
        .bp_hit    (bp_hit),
        .cycle_cnt (cycle_cnt)
    );

    cpu_exec_ctrl #(.PC_W(32), .CNT_W(8), .CYC_W(4)) u_sat (
        .clk       (clk),
        .rst       (rst),
        .run       (run_s),
        .step      (1'b0),
        .step_num  (8'd0),
        .bp_en     (1'b0),
        .bp_addr   (32'd0),
        .pc        (32'd0),
        .halt_req  (1'b0),
        .cpu_ce    (cpu_ce_s),
        .state     (state_s),
        .bp_hit    (bp_hit_s),
        .cycle_cnt (cycle_cnt_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Minimal CPU: the fetch PC advances by one word per enabled cycle.
    initial cpu_pc = '0;
    always @(posedge clk) begin
        if (pc_clr)
            cpu_pc <= '0;
        else if (cpu_ce)
            cpu_pc <= cpu_pc + 32'd4;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int unsigned max_cyc, input string name);
        for (int unsigned i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (state == s) break;
        end
        check(name, {30'd0, state}, {30'd0, s});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pc_clr = 1'b1;
        @(negedge clk);
        pc_clr = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  num;
        int unsigned exp_ce;
    } step_vec_t;

    step_vec_t   vecs [6];
    logic [31:0] exp_cnt;
    logic [31:0] saved_pc;
    int unsigned n_ce, n_st;
    logic        seen;

    initial begin
        vecs[0] = '{num: 8'd3,  exp_ce: 3};
        vecs[1] = '{num: 8'd0,  exp_ce: 1};
        vecs[2] = '{num: 8'd1,  exp_ce: 1};
        vecs[3] = '{num: 8'd5,  exp_ce: 5};
        vecs[4] = '{num: 8'd2,  exp_ce: 2};
        vecs[5] = '{num: 8'd16, exp_ce: 16};

        rst = 1'b0; run = 1'b0; step = 1'b0; bp_en = 1'b0; halt_req = 1'b0;
        step_num = '0; bp_addr = '0; pc_clr = 1'b0; run_s = 1'b0;
        exp_cnt = '0;

        repeat (3) @(negedge clk);
        check("rst_state",  {30'd0, state}, 32'd0);
        check("rst_ce",     {31'd0, cpu_ce}, 32'd0);
        check("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
        check("rst_cycles", cycle_cnt, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Step table: enable count, cycles spent in STEP, return to IDLE.
        for (int unsigned v = 0; v < 6; v++) begin
            step_num = vecs[v].num;
            step     = 1'b1;
            n_ce = 0;
            n_st = 0;
            for (int unsigned i = 0; i < 40; i++) begin
                @(negedge clk);
                if (cpu_ce) n_ce++;
                if (state == 2'b10) n_st++;
            end
            step = 1'b0;
            exp_cnt = exp_cnt + vecs[v].exp_ce;
            check("step_ce",        n_ce, vecs[v].exp_ce);
            check("step_cycles",    n_st, vecs[v].exp_ce);
            check("step_end_state", {30'd0, state}, 32'd0);
            check("step_cycle_cnt", cycle_cnt, exp_cnt);
            repeat (4) @(negedge clk);
        end

        // Breakpoint at 0x10 while running from pc 0.
        pc_clr = 1'b1;
        @(negedge clk);
        pc_clr = 1'b0;
        @(negedge clk);
        bp_en = 1'b1; bp_addr = 32'h10; run = 1'b1;
        n_ce = 0;
        seen = 1'b0;
        for (int unsigned i = 0; i < 30; i++) begin
            @(negedge clk);
            if (state == 2'b01 && cpu_pc == 32'h10 && !seen) begin
                check("ce_low_at_bp", {31'd0, cpu_ce}, 32'd0);
                seen = 1'b1;
            end
            if (cpu_ce) n_ce++;
            if (state == 2'b11) break;
        end
        exp_cnt = exp_cnt + 4;
        check("bp_halt_state", {30'd0, state}, 32'd3);
        check("bp_ce_cycles",  n_ce, 32'd4);
        check("bp_hit_set",    {31'd0, bp_hit}, 32'd1);
        check("bp_pc",         cpu_pc, 32'h10);
        check("bp_cycle_cnt",  cycle_cnt, exp_cnt);
        repeat (3) @(negedge clk);
        check("halt_holds_pc", cpu_pc, 32'h10);
        check("halt_ce_low",   {31'd0, cpu_ce}, 32'd0);

        // Single step off the breakpoint PC.
        step_num = 8'd1;
        step = 1'b1;
        n_ce = 0;
        for (int unsigned i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cpu_ce) n_ce++;
        end
        step = 1'b0;
        exp_cnt = exp_cnt + 1;
        check("skip_step_ce",    n_ce, 32'd1);
        check("skip_step_state", {30'd0, state}, 32'd0);
        check("skip_bp_hit",     {31'd0, bp_hit}, 32'd1);
        check("skip_pc",         cpu_pc, 32'h14);
        check("skip_cycle_cnt",  cycle_cnt, exp_cnt);

        run = 1'b0;
        repeat (4) @(negedge clk);
        run = 1'b1;
        wait_state(2'b01, 10, "rerun_state");
        check("rerun_bp_clr", {31'd0, bp_hit}, 32'd0);
        run = 1'b0;
        wait_state(2'b00, 10, "run_off_idle");
        bp_en = 1'b0;

        // Halt request on the sixth enabled cycle after a fresh reset.
        do_reset();
        run = 1'b1;
        n_ce = 0;
        for (int unsigned i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cpu_ce) n_ce++;
            if (n_ce == 5) break;
        end
        @(posedge clk);
        #1 halt_req = 1'b1;
        @(negedge clk);
        check("halt_req_ce_low", {31'd0, cpu_ce}, 32'd0);
        check("halt_req_in_run", {30'd0, state}, 32'd1);
        @(negedge clk);
        check("halt_req_state",  {30'd0, state}, 32'd3);
        check("halt_req_cycles", cycle_cnt, 32'd5);
        check("halt_req_bp_hit", {31'd0, bp_hit}, 32'd0);
        check("halt_req_pc",     cpu_pc, 32'h14);

        // Stop conditions coinciding with the run switch going low.
        run = 1'b0;
        repeat (4) @(negedge clk);
        halt_req = 1'b0;
        run = 1'b1;
        wait_state(2'b01, 10, "combo_run_state");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 run = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        saved_pc = cpu_pc;
        bp_addr  = cpu_pc;
        bp_en    = 1'b1;
        halt_req = 1'b1;
        @(negedge clk);
        check("combo_ce_low", {31'd0, cpu_ce}, 32'd0);
        check("combo_in_run", {30'd0, state}, 32'd1);
        @(negedge clk);
        check("combo_state",  {30'd0, state}, 32'd3);
        check("combo_bp_hit", {31'd0, bp_hit}, 32'd1);
        check("combo_pc",     cpu_pc, saved_pc);
        halt_req = 1'b0;
        bp_en    = 1'b0;

        // Asynchronous reset in the middle of a long step.
        do_reset();
        step_num = 8'd200;
        step = 1'b1;
        wait_state(2'b10, 10, "long_step_state");
        check("long_step_cnt0", cycle_cnt, 32'd0);
        repeat (50) @(negedge clk);
        check("long_step_cnt50", cycle_cnt, 32'd50);
        check("long_step_still", {30'd0, state}, 32'd2);
        #2 rst = 1'b0;
        #1;
        check("async_rst_ce",     {31'd0, cpu_ce}, 32'd0);
        check("async_rst_state",  {30'd0, state}, 32'd0);
        check("async_rst_cycles", cycle_cnt, 32'd0);
        step = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n_ce = 0;
        for (int unsigned i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_ce) n_ce++;
        end
        check("post_rst_no_ce", n_ce, 32'd0);
        check("post_rst_idle",  {30'd0, state}, 32'd0);

        // Run and step edges in the same cycle: run wins.
        step_num = 8'd4;
        run  = 1'b1;
        step = 1'b1;
        repeat (4) @(negedge clk);
        check("run_beats_step", {30'd0, state}, 32'd1);
        run  = 1'b0;
        step = 1'b0;
        wait_state(2'b00, 10, "run_beats_idle");

        // Saturation on the 4-bit counter build.
        run_s = 1'b1;
        for (int unsigned i = 0; i < 10; i++) begin
            @(negedge clk);
            if (state_s == 2'b01) break;
        end
        check("sat_run_state", {30'd0, state_s}, 32'd1);
        check("sat_cnt0",      {28'd0, cycle_cnt_s}, 32'd0);
        repeat (14) @(negedge clk);
        check("sat_cnt14",     {28'd0, cycle_cnt_s}, 32'hE);
        @(negedge clk);
        check("sat_cnt15",     {28'd0, cycle_cnt_s}, 32'hF);
        repeat (20) @(negedge clk);
        check("sat_hold",      {28'd0, cycle_cnt_s}, 32'hF);
        check("sat_ce_on",     {31'd0, cpu_ce_s}, 32'd1);
        run_s = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
